// File: rtl/timer_pkg.sv
// Shared types and defaults for the lab timing blocks.
// The state encoding is fixed at 2 bits so that state can be probed the same way on every timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } timer_state_t;

  localparam int TIMER_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/pause control, a one-cycle terminal-count pulse
// and an optional periodic reload. Every output comes straight from a flop.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             done
);

  timer_state_t     state_reg;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] reload_reg;
  logic             done_reg;
  logic             busy_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      reload_reg <= '0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (load) begin
        count_reg  <= load_value;
        reload_reg <= load_value;
        state_reg  <= IDLE;
        busy_reg   <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start && (count_reg != '0)) begin
              state_reg <= RUN;
              busy_reg  <= 1'b1;
            end
          end
          RUN: begin
            // A zero count in RUN is the terminal-count cycle (done is high now).
            if (count_reg == '0) begin
              if (auto_reload && (reload_reg != '0)) begin
                count_reg <= reload_reg;
              end else begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
              end
            end else if (pause) begin
              state_reg <= HOLD;
            end else begin
              count_reg <= count_reg - WIDTH'(1);
              if (count_reg == WIDTH'(1)) begin
                done_reg <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (!pause && start) begin
              state_reg <= RUN;
            end
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count_out = count_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed scenarios plus random control traffic, checked cycle by cycle against
// a behavioural model of the countdown timer.
module tb_countdown_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] count_out;
  logic         busy;
  logic         done;

  countdown_timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .auto_reload(auto_reload),
    .count_out  (count_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = stopped, 1 = counting, 2 = held.
  int m_count, m_reload, m_mode, m_done;
  bit m_expired;
  int done_seen;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_reload = 0; m_mode = 0; m_done = 0; m_expired = 0;
  endtask

  task automatic model_step(input bit l, input int lv, input bit s, input bit p, input bit ar);
    int next_done;
    next_done = 0;
    if (l) begin
      m_count = lv; m_reload = lv; m_mode = 0; m_expired = 0;
    end else if (m_mode == 0) begin
      if (s && m_count > 0) m_mode = 1;
    end else if (m_mode == 1) begin
      if (m_expired) begin
        m_expired = 0;
        if (ar && m_reload > 0) m_count = m_reload;
        else m_mode = 0;
      end else if (p) begin
        m_mode = 2;
      end else begin
        m_count = m_count - 1;
        if (m_count == 0) begin
          next_done = 1;
          m_expired = 1;
        end
      end
    end else begin
      if (!p && s) m_mode = 1;
    end
    m_done = next_done;
  endtask

  task automatic cycle(input bit l, input int lv, input bit s, input bit p, input bit ar);
    load = l; load_value = lv[W-1:0]; start = s; pause = p; auto_reload = ar;
    @(posedge clk);
    model_step(l, lv, s, p, ar);
    #1;
    check("count", int'(count_out), m_count);
    check("busy", int'(busy), (m_mode != 0) ? 1 : 0);
    check("done", int'(done), m_done);
    if (done) done_seen++;
    $display("cyc %0t ld=%0b lv=%0d st=%0b pa=%0b ar=%0b -> count=%0d busy=%0b done=%0b",
             $time, l, lv, s, p, ar, count_out, busy, done);
  endtask

  task automatic idle_cycles(input int n, input bit ar);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b0, ar);
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    check("reset_count", int'(count_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    #3 reset = 1'b1;

    // Single shot from 5.
    done_seen = 0;
    cycle(1'b1, 5, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle_cycles(8, 1'b0);
    check("t1_dones", done_seen, 1);
    check("t1_final_count", int'(count_out), 0);

    // Periodic from 3: one done every 4 cycles.
    done_seen = 0;
    cycle(1'b1, 3, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    idle_cycles(16, 1'b1);
    check("t2_dones", done_seen, 4);
    check("t2_busy", int'(busy), 1);

    // Pause at 6 for 4 cycles, then resume.
    done_seen = 0;
    cycle(1'b1, 9, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle_cycles(3, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
    check("t3_held", int'(count_out), 6);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle_cycles(8, 1'b0);
    check("t3_dones", done_seen, 1);

    // Zero load is ignored by start; load beats start.
    done_seen = 0;
    cycle(1'b1, 0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
    check("t4_zero_busy", int'(busy), 0);
    cycle(1'b1, 7, 1'b1, 1'b0, 1'b0);
    check("t4_load_start_count", int'(count_out), 7);
    check("t4_load_start_busy", int'(busy), 0);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle_cycles(9, 1'b0);
    check("t4_dones", done_seen, 1);

    // Full range, no wrap.
    done_seen = 0;
    cycle(1'b1, 15, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle_cycles(18, 1'b0);
    check("t5_dones", done_seen, 1);
    check("t5_count", int'(count_out), 0);

    // Asynchronous reset between edges at count 4.
    cycle(1'b1, 9, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle_cycles(5, 1'b0);
    check("t6_pre_count", int'(count_out), 4);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("t6_async_count", int'(count_out), 0);
    check("t6_async_busy", int'(busy), 0);
    check("t6_async_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b1;
    idle_cycles(4, 1'b0);
    check("t6_stay_idle", int'(busy), 0);

    // Random control traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 11) == 0, int'($urandom_range(0, 15)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
